flappy_mailbox_master: RTL
==========================

Name: flappy_mailbox_master

Overview:
Avalon-MM master that drives the 4-word, 32-bit on-chip mailbox RAM from the game-logic side. The Nios II software side accesses the same RAM through its own port.
On each frame_tick the block runs one fixed sweep:
- writes a status snapshot to words 2 and 3;
- reads the command word (0) and the parameter word (1);
- presents both words to game logic with a one-cycle update strobe.

Parameters:
READ_LATENCY, 1, cycles from read issue to valid avm_readdata (1 matches the unregistered-output RAM); legal range 1..3
OVR_W, 8, width of saturating overrun counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle sweep request
score  in  16  current score
bird_y  in  10  bird vertical position
collision  in  1  collision flag
game_over  in  1  game-over flag
avm_address  out  2  word address
avm_byteenable  out  4  byte enables; always 4'hF
avm_chipselect  out  1  access strobe
avm_write  out  1  write strobe
avm_writedata  out  32  write data
avm_clken  out  1  RAM clock enable; constant 1
avm_readdata  in  32  read data
cmd_word  out  32  last captured word 0
param_word  out  32  last captured word 1
cmd_update  out  1  one-cycle pulse when cmd_word/param_word have been refreshed
busy  out  1  sweep in progress
overrun_cnt  out  OVR_W  ticks dropped while busy; saturates at all-ones

Behaviour:
- Reset values:
  - all avm_* outputs 0, except avm_byteenable=F and avm_clken=1;
  - cmd_word=0, param_word=0, cmd_update=0, busy=0, overrun_cnt=0;
  - FSM in IDLE.
- Word layout:
  - word0: bit31 valid, bits7:0 command code;
  - word1: parameters, opaque to this block;
  - word2 = {game_over, collision, 20'b0, bird_y};
  - word3 = {16'b0, score}.
- Status snapshot: the status inputs are registered on the cycle the tick is accepted. Both status writes use the snapshot, never live inputs.
- FSM states and order: IDLE -> WR_STAT -> WR_SCORE -> RD_CMD -> WT_CMD -> RD_PARAM -> WT_PARAM -> [ACK] -> DONE -> IDLE.
- Per-state bus activity:
  - WR_STAT: chipselect=1, write=1, address=2, writedata=word2; one cycle.
  - WR_SCORE: same, with address=3 and word3.
  - RD_CMD and RD_PARAM: chipselect=1, write=0, address=0 or 1; one cycle.
  - WT_*: chipselect=0 and write=0, but avm_address is held at the read address. The RAM address register loads every enabled clock, so the address must stay stable.
- Read capture: avm_readdata is sampled exactly READ_LATENCY cycles after the issue edge. WT_* therefore lasts READ_LATENCY cycles, counted by an internal 2-bit counter.
- Timeline with READ_LATENCY=1 and the tick accepted at cycle T:
  - T+1 write word2; T+2 write word3;
  - T+3 issue read 0; T+4 capture cmd;
  - T+5 issue read 1; T+6 capture param;
  - T+7 DONE: cmd_update=1, busy returns 0 at T+8.
- busy is high from T+1 through DONE inclusive.
- cmd_word and param_word change only in DONE; both update together.
- A tick is accepted only in IDLE.
  - A frame_tick in any other state is dropped and increments overrun_cnt, saturating.
  - A tick in the DONE cycle counts as an overrun.
- Reset asserted mid-sweep:
  - returns immediately to reset values;
  - a status write already issued may have landed in RAM; this is acceptable;
  - no cmd_update is produced for the aborted sweep.
- avm_writedata is 0 whenever avm_write=0.

Optional Feature:
MAILBOX_ACK_EN
- Defined:
  - if the captured word0 has bit31=1, an ACK state follows WT_PARAM;
  - ACK writes word0 with bit31 cleared and bits30:0 unchanged (chipselect=1, write=1, address=0);
  - this adds one cycle, so DONE moves to T+8;
  - when bit31=0, ACK is skipped.
- Undefined: no ACK state; the block never writes word0 or word1.

Decomposition:
- Package flappy_mailbox_pkg holds:
  - address constants ADDR_CMD=0, ADDR_PARAM=1, ADDR_STAT=2, ADDR_SCORE=3;
  - CMD_VALID_BIT=31;
  - the FSM state enum;
  - a function packing status fields into word2.
- No sub-module; the latency counter and FSM are small enough to stay inline.

Test Plan:
- Reset, then a single tick with score=0x0123, bird_y=0x155, collision=1, game_over=0:
  - writes 0x40000155 to addr2 at T+1 and 0x00000123 to addr3 at T+2;
  - cmd_update pulses at T+7.
- Software preloads word0=0x80000005 and word1=0xDEADBEEF, then a tick:
  - cmd_word=0x80000005 and param_word=0xDEADBEEF in DONE.
  - With MAILBOX_ACK_EN, RAM word0 reads 0x00000005 afterwards and cmd_update is at T+8.
- Ticks at T and T+3:
  - overrun_cnt=1 and exactly one sweep occurs.
  - Holding frame_tick high for 300 cycles saturates overrun_cnt at 0xFF.
- READ_LATENCY=3 with a 3-stage readdata model:
  - correct capture;
  - avm_address held during each 3-cycle wait;
  - cmd_update at T+11.
- Change score during the sweep after tick acceptance: word3 still holds the snapshot value.
- Assert reset at T+4:
  - all outputs return to reset values the next cycle;
  - no cmd_update;
  - cmd_word remains 0.

Source files
------------

// File: rtl/flappy_mailbox_pkg.sv
// Shared constants, FSM state type and status packing for the
// game-side mailbox master.
package flappy_mailbox_pkg;

   localparam logic [1:0] ADDR_CMD   = 2'd0;
   localparam logic [1:0] ADDR_PARAM = 2'd1;
   localparam logic [1:0] ADDR_STAT  = 2'd2;
   localparam logic [1:0] ADDR_SCORE = 2'd3;

   localparam int CMD_VALID_BIT = 31;

   typedef enum logic [3:0] {
      IDLE,
      WR_STAT,
      WR_SCORE,
      RD_CMD,
      WT_CMD,
      RD_PARAM,
      WT_PARAM,
      ACK,
      DONE
   } state_t;

   function automatic logic [31:0] pack_stat(
      input logic       game_over,
      input logic       collision,
      input logic [9:0] bird_y
   );
      return {game_over, collision, 20'b0, bird_y};
   endfunction

endpackage

// File: rtl/flappy_mailbox_if.sv
// Avalon-MM bundle between the mailbox master and the
// game-side port of the mailbox RAM.
interface flappy_mailbox_if;

   logic [1:0]  avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_chipselect;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_clken;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_byteenable,
      output avm_chipselect,
      output avm_write,
      output avm_writedata,
      output avm_clken,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_byteenable,
      input  avm_chipselect,
      input  avm_write,
      input  avm_writedata,
      input  avm_clken,
      output avm_readdata
   );

endinterface

// File: rtl/flappy_mailbox_master.sv
// Per-frame mailbox sweep: status writes, command/param reads.
// Define MAILBOX_ACK_EN to clear the command valid bit after capture.
module flappy_mailbox_master
   import flappy_mailbox_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int OVR_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic [15:0]      score,
   input  logic [9:0]       bird_y,
   input  logic             collision,
   input  logic             game_over,
   flappy_mailbox_if.master avm,
   output logic [31:0]      cmd_word,
   output logic [31:0]      param_word,
   output logic             cmd_update,
   output logic             busy,
   output logic [OVR_W-1:0] overrun_cnt
);

   state_t      state;
   state_t      state_d;
   logic [1:0]  wt_cnt;
   logic        wt_last;
   logic        accept;
   logic [15:0] snap_score;
   logic [9:0]  snap_y;
   logic        snap_coll;
   logic        snap_go;
   logic [31:0] cmd_cap;
   logic [31:0] param_cap;

   logic [1:0]  address;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;

   assign accept  = (state == IDLE) && frame_tick;
   assign wt_last = (wt_cnt == 2'(READ_LATENCY - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:     if (frame_tick) state_d = WR_STAT;
         WR_STAT:  state_d = WR_SCORE;
         WR_SCORE: state_d = RD_CMD;
         RD_CMD:   state_d = WT_CMD;
         WT_CMD:   if (wt_last) state_d = RD_PARAM;
         RD_PARAM: state_d = WT_PARAM;
         WT_PARAM: begin
            if (wt_last) begin
`ifdef MAILBOX_ACK_EN
               state_d = cmd_cap[CMD_VALID_BIT] ? ACK : DONE;
`else
               state_d = DONE;
`endif
            end
         end
         ACK:      state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      address    = ADDR_CMD;
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      unique case (state)
         WR_STAT: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = ADDR_STAT;
            writedata  = pack_stat(snap_go, snap_coll, snap_y);
         end
         WR_SCORE: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = ADDR_SCORE;
            writedata  = {16'b0, snap_score};
         end
         RD_CMD: begin
            chipselect = 1'b1;
            address    = ADDR_CMD;
         end
         WT_CMD:   address = ADDR_CMD;
         RD_PARAM: begin
            chipselect = 1'b1;
            address    = ADDR_PARAM;
         end
         WT_PARAM: address = ADDR_PARAM;
`ifdef MAILBOX_ACK_EN
         ACK: begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = ADDR_CMD;
            writedata  = {1'b0, cmd_cap[30:0]};
         end
`endif
         default: ;
      endcase
   end

   assign avm.avm_address    = address;
   assign avm.avm_chipselect = chipselect;
   assign avm.avm_write      = write;
   assign avm.avm_writedata  = writedata;
   assign avm.avm_byteenable = 4'hF;
   assign avm.avm_clken      = 1'b1;

   // Wait counter restarts on every read issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         wt_cnt <= '0;
      end else if (state == RD_CMD || state == RD_PARAM) begin
         wt_cnt <= '0;
      end else if (state == WT_CMD || state == WT_PARAM) begin
         wt_cnt <= wt_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_score <= '0;
         snap_y     <= '0;
         snap_coll  <= 1'b0;
         snap_go    <= 1'b0;
      end else if (accept) begin
         snap_score <= score;
         snap_y     <= bird_y;
         snap_coll  <= collision;
         snap_go    <= game_over;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_cap   <= '0;
         param_cap <= '0;
      end else begin
         if (state == WT_CMD && wt_last) cmd_cap <= avm.avm_readdata;
         if (state == WT_PARAM && wt_last) param_cap <= avm.avm_readdata;
      end
   end

   // Published words become visible together on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_word   <= '0;
         param_word <= '0;
      end else if (state_d == DONE && state != DONE) begin
         cmd_word   <= cmd_cap;
         param_word <= (state == WT_PARAM) ? avm.avm_readdata : param_cap;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_cnt <= '0;
      end else if (frame_tick && state != IDLE && overrun_cnt != '1) begin
         overrun_cnt <= overrun_cnt + 1'b1;
      end
   end

   assign busy       = (state != IDLE);
   assign cmd_update = (state == DONE);

endmodule
